// File: rtl/csa_adder_8bit.sv
// 8-bit carry-select adder with registered {out,sum}; BLOCK_W-bit ripple blocks.
// Define CSA_OVF_EN to add the registered signed-overflow output ovf.

module csa_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module csa_ripple #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    // One scalar carry per bit keeps the chain free of self-referencing vectors.
    for (genvar i = 0; i < W; i++) begin : bit_g
        logic c_in;
        logic c_out;
        if (i == 0) begin : g_first
            assign c_in = ci;
        end else begin : g_next
            assign c_in = bit_g[i-1].c_out;
        end
        csa_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_in),
            .s  (s[i]),
            .co (c_out)
        );
    end
    assign co = bit_g[W-1].c_out;
endmodule

module csa_adder_8bit #(
    parameter int BLOCK_W = 4   // 2 or 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic       cin,
    output logic       out,
    output logic [7:0] sum
`ifdef CSA_OVF_EN
    ,
    output logic       ovf
`endif
);
    localparam int NBLK = 8 / BLOCK_W;

    logic [7:0] sum_p0;
    logic       cout_p0;

    for (genvar k = 0; k < NBLK; k++) begin : blk_g
        logic cout;
        if (k == 0) begin : g_low
            csa_ripple #(.W(BLOCK_W)) u_rc (
                .a  (in0[k*BLOCK_W +: BLOCK_W]),
                .b  (in1[k*BLOCK_W +: BLOCK_W]),
                .ci (cin),
                .s  (sum_p0[k*BLOCK_W +: BLOCK_W]),
                .co (cout)
            );
        end else begin : g_sel
            logic               csel;
            logic [BLOCK_W-1:0] s0;
            logic [BLOCK_W-1:0] s1;
            logic               c0;
            logic               c1;
            csa_ripple #(.W(BLOCK_W)) u_rc0 (
                .a  (in0[k*BLOCK_W +: BLOCK_W]),
                .b  (in1[k*BLOCK_W +: BLOCK_W]),
                .ci (1'b0),
                .s  (s0),
                .co (c0)
            );
            csa_ripple #(.W(BLOCK_W)) u_rc1 (
                .a  (in0[k*BLOCK_W +: BLOCK_W]),
                .b  (in1[k*BLOCK_W +: BLOCK_W]),
                .ci (1'b1),
                .s  (s1),
                .co (c1)
            );
            assign csel                         = blk_g[k-1].cout;
            assign sum_p0[k*BLOCK_W +: BLOCK_W] = csel ? s1 : s0;
            assign cout                         = csel ? c1 : c0;
        end
    end

    assign cout_p0 = blk_g[NBLK-1].cout;

    // stage p0 -> output register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sum <= 8'h00;
            out <= 1'b0;
        end else begin
            sum <= sum_p0;
            out <= cout_p0;
        end
    end

`ifdef CSA_OVF_EN
    logic ovf_p0;
    assign ovf_p0 = (in0[7] == in1[7]) && (sum_p0[7] != in0[7]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_p0;
        end
    end
`endif

endmodule

// File: tb/tb_csa_adder_8bit.sv
// Self-checking bench for csa_adder_8bit: vector table, reset corner cases, full operand-pair sweep.
// Honours CSA_OVF_EN the same way as the design.

module tb_csa_adder_8bit;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       cin;
    logic       out;
    logic [7:0] sum;
`ifdef CSA_OVF_EN
    logic       ovf;
`endif

    csa_adder_8bit #(.BLOCK_W(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .in0    (in0),
        .in1    (in1),
        .cin    (cin),
        .out    (out),
        .sum    (sum)
`ifdef CSA_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         id;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   nchk = 0;
    int   nerr = 0;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input int id);
        exp_t       e;
        logic [8:0] r;
        r    = {1'b0, a} + {1'b0, b} + {8'd0, c};
        e.s  = r[7:0];
        e.co = r[8];
        e.ov = (a[7] == b[7]) && (r[7] != a[7]);
        e.id = id;
        return e;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got {out,sum}=%h required %h", name, act, req);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        nchk++;
        if (sb.size() == 0) begin
            nerr++;
            $display("FAIL scoreboard: result with no pending expectation, got %h", {out, sum});
        end else begin
            e = sb.pop_front();
            if ({out, sum} !== {e.co, e.s}) begin
                nerr++;
                $display("FAIL op%0d: got {out,sum}=%h required %h", e.id, {out, sum}, {e.co, e.s});
            end
`ifdef CSA_OVF_EN
            nchk++;
            if (ovf !== e.ov) begin
                nerr++;
                $display("FAIL op%0d ovf: got %b required %b", e.id, ovf, e.ov);
            end
`endif
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input exp_t e);
        @(negedge clock);
        in0 = a;
        in1 = b;
        cin = c;
        sb.push_back(e);
        @(posedge clock);
        #1;
        pop_check();
    endtask

    task automatic chk_zero(input string name);
        chk(name, {out, sum}, 9'h000);
`ifdef CSA_OVF_EN
        nchk++;
        if (ovf !== 1'b0) begin
            nerr++;
            $display("FAIL %s ovf: got %b required 0", name, ovf);
        end
`endif
    endtask

    initial begin
        exp_t e;
        vecs[0]  = '{8'h8C, 8'h0C, 1'b0, 8'h98, 1'b0, 1'b0};
        vecs[1]  = '{8'h84, 8'h04, 1'b0, 8'h88, 1'b0, 1'b0};
        vecs[2]  = '{8'h84, 8'h84, 1'b0, 8'h08, 1'b1, 1'b1};
        vecs[3]  = '{8'h84, 8'h84, 1'b1, 8'h09, 1'b1, 1'b1};
        vecs[4]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[5]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{8'h07, 8'h08, 1'b1, 8'h10, 1'b0, 1'b0};

        resetn = 1'b0;
        in0    = 8'h00;
        in1    = 8'h00;
        cin    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset");
        @(negedge clock);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            e = '{s: vecs[i].s, co: vecs[i].co, ov: vecs[i].ov, id: i};
            drive(vecs[i].a, vecs[i].b, vecs[i].c, e);
        end

        // Asynchronous reset mid-period drops the held result; release loads current operands.
        e = '{s: 8'h98, co: 1'b0, ov: 1'b0, id: 100};
        drive(8'h8C, 8'h0C, 1'b0, e);
        @(negedge clock);
        in0 = 8'h84;
        in1 = 8'h04;
        cin = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk_zero("t6_async_reset");
        @(posedge clock);
        #1;
        chk_zero("t6_hold_in_reset");
        @(negedge clock);
        resetn = 1'b1;
        sb.push_back('{s: 8'h88, co: 1'b0, ov: 1'b0, id: 101});
        @(posedge clock);
        #1;
        pop_check();

        // Every operand pair once, carry-in varied across the sweep.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            logic        c;
            v = 16'(i);
            c = v[0] ^ v[8] ^ v[15] ^ v[4];
            drive(v[15:8], v[7:0], c, model(v[15:8], v[7:0], c, 1000 + i));
        end
        for (int i = 0; i < 512; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic       c;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            drive(a, b, c, model(a, b, c, 70000 + i));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
